lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator sitting between the CPU execute/memory stage and the byte-addressed data memory port (`enable`/`read`/`addr`/`func`/`data_in`/`data_out`). It accepts one load or store request at a time over a valid/ready handshake and drives the memory port for a fixed number of wait cycles per beat. For loads it captures read data and applies RISC-V sign or zero extension, then returns a response over a second valid/ready handshake. Misaligned halfword and word accesses are either split into byte beats or rejected, depending on configuration.

## Interface
Parameters:
- `MEM_WAIT`, default 1: cycles `mem_en` is held per beat before read data is sampled. Legal range 1–15.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept a request.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_func`  in  3: RISC-V funct3.
  - Loads: 0 = LB, 1 = LH, 2 = LW, 4 = LBU, 5 = LHU.
  - Stores: 0 = SB, 1 = SH, 2 = SW.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_rdata`  out  32: extended load result. 0 for stores and errors.
- `resp_err`  out  1: illegal func, or misaligned access with splitting disabled.
- `mem_en`  out  1: memory enable.
- `mem_read`  out  1: 1 = read, 0 = write.
- `mem_addr`  out  32: beat address.
- `mem_func`  out  3: memory access size.
- `mem_wdata`  out  32: beat write data.
- `mem_rdata`  in  32: memory read data, valid combinationally while `mem_en` is high.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch the request.
  - Illegal func (3, 6, 7; or a store with func > 2) → RESP with `resp_err` = 1.
  - Misaligned access (LH/LHU/SH with addr[0] ≠ 0, or LW/SW with addr[1:0] ≠ 0) → RESP with error, unless `LSU_SPLIT_EN` is defined.
  - Otherwise → ACCESS.
- Memory func issued:
  - Reads always use the unsigned/full forms: 4 for bytes, 5 for halfwords, 2 for words.
  - Sign extension is done internally from bit 7 or bit 15 of the assembled value. The memory's signed-read encodings are never used.
  - Writes use 0, 1 or 2.
- Beats:
  - Aligned access: 1 beat, at `mem_addr` = `req_addr`, `mem_func` as above.
  - Split access: N byte beats, N = 2 (half) or N = 4 (word).
  - Split beat i: `mem_addr` = `req_addr` + i (32-bit wrap-around, 0xFFFFFFFF+1 = 0), `mem_func` = 4 for reads or 0 for writes, `mem_wdata` = {24'h0, req_wdata[8i+7:8i]}.
  - Read byte i goes into assembly bits [8i+7:8i].
- ACCESS:
  - `mem_en` = 1 and `mem_read` = !req_we.
  - A wait counter runs 0..MEM_WAIT−1.
  - On the last wait cycle's edge: sample `mem_rdata` (loads), then advance the beat counter.
  - After the last beat → RESP.
  - `mem_en` stays high across consecutive beats; only address and data change.
- RESP:
  - `resp_valid` = 1, all memory outputs are 0.
  - `resp_rdata` and `resp_err` are held stable until `resp_ready`, then → IDLE.
  - `req_ready` = 0 outside IDLE. There is no request pipelining.

## Timing
- Reset values: `req_ready` = 1 after reset release; every other output = 0.
- Reset asserted mid-operation: `mem_en`, `resp_valid` and all state clear immediately (asynchronously), and the in-flight request is dropped. Memory writes already performed are not undone.
- Request accepted at edge T (valid & ready):
  - `mem_en` is high from T to T + N·MEM_WAIT.
  - `resp_valid` is high from edge T + N·MEM_WAIT.
  - Aligned accesses use N = 1.
- Error path: `resp_valid` at edge T+1. `mem_en` is never asserted.
- Response handshake: completes at the edge where `resp_valid` & `resp_ready` are both high. `req_ready` rises in the following cycle. Minimum issue interval is N·MEM_WAIT + 2 cycles.
- A request presented during RESP is ignored, and must be held by the requester.

## Configuration
- `LSU_SPLIT_EN` defined:
  - Misaligned LH/LHU/LW/SH/SW are split into byte beats as described.
  - `resp_err` is only set for an illegal func.
- `LSU_SPLIT_EN` undefined:
  - Misaligned accesses return `resp_err` = 1 at T+1 with no memory activity.
  - Beat counter and assembly logic are removed; all accesses are single-beat.

## Test plan
- LW at 0x100, memory holds 0xDEADBEEF, MEM_WAIT = 1:
  - `mem_func` = 2 and `mem_read` = 1 during T.
  - `resp_rdata` = 0xDEADBEEF, `resp_err` = 0, `resp_valid` at T+1.
- LB at 0x103 where the byte is 0x80: `mem_func` = 4, `resp_rdata` = 0xFFFFFF80. LBU at the same address: 0x00000080.
- SH with wdata 0x1234ABCD at 0x202: `mem_func` = 1 and `mem_read` = 0. A following LHU at 0x202 returns 0x0000ABCD; LH returns 0xFFFFABCD.
- LW at 0x101, memory bytes 0x11, 0x22, 0x33, 0x44 at 0x101–0x104, MEM_WAIT = 2:
  - With `LSU_SPLIT_EN`: beats at 0x101–0x104 with `mem_func` = 4, `resp_rdata` = 0x44332211, `resp_valid` at T+8.
  - Without `LSU_SPLIT_EN`: `resp_err` = 1 at T+1 and `mem_en` never goes high.
- Illegal func 3 on a load, and func 4 on a store: `resp_err` = 1, `resp_rdata` = 0, no `mem_en`.
- Backpressure and reset:
  - Hold `resp_ready` low for 5 cycles: `resp_valid`/`resp_rdata` stay stable.
  - Assert `rst` mid-ACCESS: `mem_en` drops the same cycle, and `req_ready` = 1 after release.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// Request/response handshakes and byte-addressed data-memory port of the LSU.
// The master modport is the LSU side; slave is the CPU/memory environment side.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [2:0]  mem_func;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_func, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_read, mem_addr,
           mem_func, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_func, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_read, mem_addr,
           mem_func, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator with RISC-V load extension and registered outputs.
// Define LSU_SPLIT_EN to split misaligned half/word accesses into byte beats instead of erroring.
module lsu_mem_master #(
  parameter int unsigned MEM_WAIT = 1
) (
  input logic              clk,
  input logic              rst,
  lsu_mem_master_if.master bus
);
  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q;
  logic        req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_en_q, mem_read_q;
  logic [2:0]  mem_func_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        we_q, err_q;
  logic [2:0]  func_q;
  logic [3:0]  wait_q;

  logic        func_ok, misaligned, bad, wait_done, last_beat;
  logic [2:0]  rd_func;
  logic [31:0] raw_data, load_data;

  assign func_ok    = bus.req_we ? (bus.req_func <= 3'd2)
                                 : (bus.req_func <= 3'd5 && bus.req_func[1:0] != 2'd3);
  assign misaligned = (bus.req_func[1:0] == 2'd1 && bus.req_addr[0]) ||
                      (bus.req_func[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0);
  assign wait_done  = (wait_q == 4'(MEM_WAIT - 1));

  // Reads always use the zero-extending memory encodings; sign extension is done here.
  always_comb begin
    case (bus.req_func[1:0])
      2'd0:    rd_func = 3'd4;
      2'd1:    rd_func = 3'd5;
      default: rd_func = 3'd2;
    endcase
  end

`ifdef LSU_SPLIT_EN
  logic        split_q;
  logic [1:0]  beat_q, last_q, beat_nxt;
  logic [31:0] addr_q, wdata_q, asm_q, asm_nxt;

  assign bad       = !func_ok;
  assign beat_nxt  = beat_q + 2'd1;
  assign asm_nxt   = asm_q | ({24'h0, bus.mem_rdata[7:0]} << {beat_q, 3'b000});
  assign last_beat = (beat_q == last_q);
  assign raw_data  = split_q ? asm_nxt : bus.mem_rdata;
`else
  assign bad       = !func_ok || misaligned;
  assign last_beat = 1'b1;
  assign raw_data  = bus.mem_rdata;
`endif

  always_comb begin
    case (func_q)
      3'd0:    load_data = {{24{raw_data[7]}}, raw_data[7:0]};
      3'd1:    load_data = {{16{raw_data[15]}}, raw_data[15:0]};
      3'd4:    load_data = {24'h0, raw_data[7:0]};
      3'd5:    load_data = {16'h0, raw_data[15:0]};
      default: load_data = raw_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_func_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      func_q       <= '0;
      wait_q       <= '0;
`ifdef LSU_SPLIT_EN
      split_q      <= 1'b0;
      beat_q       <= '0;
      last_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            state_q     <= StAccess;
            req_ready_q <= 1'b0;
            we_q        <= bus.req_we;
            func_q      <= bus.req_func;
            wait_q      <= '0;
            err_q       <= bad;
            // Errors spend one silent cycle in StAccess so the response lands at T+1.
            if (!bad) begin
              mem_en_q    <= 1'b1;
              mem_read_q  <= !bus.req_we;
              mem_addr_q  <= bus.req_addr;
              mem_func_q  <= bus.req_we ? {1'b0, bus.req_func[1:0]} : rd_func;
              mem_wdata_q <= bus.req_we ? bus.req_wdata : '0;
`ifdef LSU_SPLIT_EN
              if (misaligned) begin
                mem_func_q  <= bus.req_we ? 3'd0 : 3'd4;
                mem_wdata_q <= bus.req_we ? {24'h0, bus.req_wdata[7:0]} : '0;
              end
`endif
            end
`ifdef LSU_SPLIT_EN
            split_q <= misaligned;
            beat_q  <= '0;
            last_q  <= misaligned ? (bus.req_func[1] ? 2'd3 : 2'd1) : 2'd0;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            asm_q   <= '0;
`endif
          end
        end
        StAccess: begin
          if (err_q) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else if (!wait_done) begin
            wait_q <= wait_q + 4'd1;
          end else begin
            wait_q <= '0;
            if (last_beat) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= we_q ? '0 : load_data;
              mem_en_q     <= 1'b0;
              mem_read_q   <= 1'b0;
              mem_func_q   <= '0;
              mem_addr_q   <= '0;
              mem_wdata_q  <= '0;
            end
`ifdef LSU_SPLIT_EN
            else begin
              beat_q      <= beat_nxt;
              asm_q       <= asm_nxt;
              mem_addr_q  <= addr_q + {30'h0, beat_nxt};
              mem_wdata_q <= we_q ? {24'h0, wdata_q[{beat_nxt, 3'b000} +: 8]} : '0;
            end
`endif
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_func   = mem_func_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed vector table, reset/backpressure sequences and random
// traffic checked against a byte-array reference model. Expectations follow LSU_SPLIT_EN.
module tb_lsu_mem_master;
  localparam int unsigned MW = 2;
`ifdef LSU_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  lsu_mem_master_if bus ();

  lsu_mem_master #(.MEM_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory device (mem) and reference model image (ref_mem), 1 KiB window on addr[9:0].
  bit [7:0]   mem     [1024];
  bit [7:0]   ref_mem [1024];
  logic       poke_en = 1'b0;
  logic [9:0] poke_addr = '0;
  logic [7:0] poke_data = '0;
  logic [9:0] wa;

  assign wa = bus.mem_addr[9:0];

  always_comb begin
    bus.mem_rdata = 32'hBAD0_BAD0;
    case (bus.mem_func)
      3'd4: bus.mem_rdata = {24'h0, mem[wa]};
      3'd5: bus.mem_rdata = {16'h0, mem[10'(wa + 10'd1)], mem[wa]};
      3'd2: bus.mem_rdata = {mem[10'(wa + 10'd3)], mem[10'(wa + 10'd2)],
                             mem[10'(wa + 10'd1)], mem[wa]};
      default: bus.mem_rdata = 32'hBAD0_BAD0;
    endcase
  end

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (bus.mem_en && !bus.mem_read) begin
      case (bus.mem_func)
        3'd0: mem[wa] <= bus.mem_wdata[7:0];
        3'd1: begin
          mem[wa]               <= bus.mem_wdata[7:0];
          mem[10'(wa + 10'd1)]  <= bus.mem_wdata[15:8];
        end
        3'd2: begin
          mem[wa]               <= bus.mem_wdata[7:0];
          mem[10'(wa + 10'd1)]  <= bus.mem_wdata[15:8];
          mem[10'(wa + 10'd2)]  <= bus.mem_wdata[23:16];
          mem[10'(wa + 10'd3)]  <= bus.mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tcmp(input int c, input string what, input logic [31:0] a, input logic [31:0] e,
                      inout int nbad, inout string det);
    if (a !== e) begin
      nbad++;
      if (det == "") det = $sformatf(" [cycle %0d %s actual=%h required=%h]", c, what, a, e);
    end
  endtask

  task automatic poke(input bit [31:0] a, input bit [7:0] d);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = a[9:0];
    poke_data = d;
    ref_mem[a[9:0]] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Reference model: architectural effect of one request on the byte image.
  function automatic void ref_access(input bit we, input bit [2:0] func, input bit [31:0] addr,
                                     input bit [31:0] wdata, output bit err,
                                     output bit [31:0] rdata, output int n, output bit split);
    int       bytes = 1 << func[1:0];
    bit       legal = we ? (func <= 3'd2) : (func inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bit       mis   = legal && ((addr & 32'(bytes - 1)) != 0);
    bit [31:0] v = '0;
    err = !legal || (mis && !SPLIT);
    rdata = '0;
    n = 0;
    split = 1'b0;
    if (err) return;
    split = mis;
    n = mis ? bytes : 1;
    for (int i = 0; i < bytes; i++) begin
      bit [9:0] idx = 10'(addr + 32'(i));
      if (we) ref_mem[idx] = wdata[8*i +: 8];
      else    v[8*i +: 8] = ref_mem[idx];
    end
    if (!we) begin
      case (func)
        3'd0:    rdata = {{24{v[7]}}, v[7:0]};
        3'd1:    rdata = {{16{v[15]}}, v[15:0]};
        3'd4:    rdata = v & 32'hFF;
        3'd5:    rdata = v & 32'hFFFF;
        default: rdata = v;
      endcase
    end
  endfunction

  function automatic bit [2:0] exp_mem_func(input bit we, input bit [2:0] func, input bit split);
    if (split) return we ? 3'd0 : 3'd4;
    if (we) return {1'b0, func[1:0]};
    case (func[1:0])
      2'd0:    return 3'd4;
      2'd1:    return 3'd5;
      default: return 3'd2;
    endcase
  endfunction

  task automatic do_txn(input bit we, input bit [2:0] func, input bit [31:0] addr,
                        input bit [31:0] wdata, input bit exp_err, input bit [31:0] exp_rdata,
                        input int bp, input string tag);
    bit        m_err, m_split;
    bit [31:0] m_rdata;
    int        n, lat_exp, lat, nbad, hb;
    string     det;
    logic [31:0] hold_rdata;
    logic        hold_err;
    ref_access(we, func, addr, wdata, m_err, m_rdata, n, m_split);
    lat_exp = m_err ? 1 : n * int'(MW);
    @(negedge clk);
    check({tag, " req_ready idle"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_func  = func;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    lat  = -1;
    nbad = 0;
    det  = "";
    for (int c = 0; c < 100 && lat < 0; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      tcmp(c, "req_ready", bus.req_ready, 0, nbad, det);
      if (bus.resp_valid === 1'b1) begin
        lat = c;
        tcmp(c, "mem_en", bus.mem_en, 0, nbad, det);
        tcmp(c, "mem_read", bus.mem_read, 0, nbad, det);
        tcmp(c, "mem_addr", bus.mem_addr, 0, nbad, det);
        tcmp(c, "mem_func", bus.mem_func, 0, nbad, det);
        tcmp(c, "mem_wdata", bus.mem_wdata, 0, nbad, det);
      end else if (!m_err && c < lat_exp) begin
        int beat = c / int'(MW);
        tcmp(c, "mem_en", bus.mem_en, 1, nbad, det);
        tcmp(c, "mem_read", bus.mem_read, 32'(!we), nbad, det);
        tcmp(c, "mem_addr", bus.mem_addr, addr + (m_split ? 32'(beat) : 32'd0), nbad, det);
        tcmp(c, "mem_func", bus.mem_func, exp_mem_func(we, func, m_split), nbad, det);
        if (we && m_split) tcmp(c, "mem_wdata", bus.mem_wdata, {24'h0, wdata[8*beat +: 8]},
                                nbad, det);
      end else begin
        tcmp(c, "mem_en", bus.mem_en, 0, nbad, det);
      end
    end
    if (lat < 0) begin
      check({tag, " resp_valid timeout"}, bus.resp_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check({tag, " latency"}, lat, lat_exp);
    check({tag, " port trace", det}, nbad, 0);
    check({tag, " resp_err"}, bus.resp_err, 32'(exp_err));
    check({tag, " resp_rdata"}, bus.resp_rdata, exp_rdata);
    hold_rdata = bus.resp_rdata;
    hold_err   = bus.resp_err;
    hb = 0;
    // A new request presented during the response must be ignored.
    for (int b = 0; b < bp; b++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_func  = 3'd2;
      bus.req_addr  = 32'h100;
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== hold_rdata || bus.resp_err !== hold_err ||
          bus.req_ready !== 1'b0 || bus.mem_en !== 1'b0) hb++;
    end
    bus.req_valid = 1'b0;
    if (bp > 0) check({tag, " backpressure hold"}, hb, 0);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, " release {req_ready,resp_valid}"}, {bus.req_ready, bus.resp_valid}, 2'b10);
  endtask

  typedef struct {
    bit        we;
    bit [2:0]  func;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        err;
    bit [31:0] rdata;
    int        bp;
  } vec_t;

  vec_t vt [24];

  initial begin
    bit        r_we, r_err, r_split;
    bit [2:0]  r_func;
    bit [31:0] r_addr, r_wdata, r_rdata;
    int        r_n, nmem;

    vt[0]  = '{1'b0, 3'd2, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 0};
    vt[1]  = '{1'b1, 3'd0, 32'h103, 32'hFFFFFF80, 1'b0, 32'h0, 0};
    vt[2]  = '{1'b0, 3'd0, 32'h103, 32'h0, 1'b0, 32'hFFFFFF80, 5};
    vt[3]  = '{1'b0, 3'd4, 32'h103, 32'h0, 1'b0, 32'h00000080, 0};
    vt[4]  = '{1'b1, 3'd1, 32'h202, 32'h1234ABCD, 1'b0, 32'h0, 1};
    vt[5]  = '{1'b0, 3'd5, 32'h202, 32'h0, 1'b0, 32'h0000ABCD, 0};
    vt[6]  = '{1'b0, 3'd1, 32'h202, 32'h0, 1'b0, 32'hFFFFABCD, 0};
    vt[7]  = '{1'b0, 3'd2, 32'h200, 32'h0, 1'b0, 32'hABCD0000, 0};
    vt[8]  = '{1'b0, 3'd3, 32'h100, 32'h0, 1'b1, 32'h0, 2};
    vt[9]  = '{1'b1, 3'd4, 32'h100, 32'hFFFFFFFF, 1'b1, 32'h0, 0};
    vt[10] = '{1'b0, 3'd6, 32'h100, 32'h0, 1'b1, 32'h0, 0};
    vt[11] = '{1'b0, 3'd7, 32'h100, 32'h0, 1'b1, 32'h0, 0};
    vt[12] = '{1'b1, 3'd0, 32'h101, 32'h11, 1'b0, 32'h0, 0};
    vt[13] = '{1'b1, 3'd0, 32'h102, 32'h22, 1'b0, 32'h0, 0};
    vt[14] = '{1'b1, 3'd0, 32'h103, 32'h33, 1'b0, 32'h0, 0};
    vt[15] = '{1'b1, 3'd0, 32'h104, 32'h44, 1'b0, 32'h0, 0};
    vt[16] = '{1'b0, 3'd2, 32'h101, 32'h0, !SPLIT, SPLIT ? 32'h44332211 : 32'h0, 3};
    vt[17] = '{1'b1, 3'd2, 32'h105, 32'h8899AABB, !SPLIT, 32'h0, 0};
    vt[18] = '{1'b0, 3'd1, 32'h107, 32'h0, !SPLIT, SPLIT ? 32'hFFFF8899 : 32'h0, 0};
    vt[19] = '{1'b0, 3'd2, 32'h104, 32'h0, 1'b0, SPLIT ? 32'h99AABB44 : 32'h00000044, 0};
    vt[20] = '{1'b0, 3'd2, 32'hFFFFFFFF, 32'h0, !SPLIT, SPLIT ? 32'h0302015A : 32'h0, 0};
    vt[21] = '{1'b1, 3'd1, 32'hFFFFFFFF, 32'h0000C3A5, !SPLIT, 32'h0, 0};
    vt[22] = '{1'b0, 3'd5, 32'hFFFFFFFF, 32'h0, !SPLIT, SPLIT ? 32'h0000C3A5 : 32'h0, 0};
    vt[23] = '{1'b0, 3'd2, 32'hFFFFFFFF, 32'h0, !SPLIT, SPLIT ? 32'h0302C3A5 : 32'h0, 0};

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_func   = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset req_ready", bus.req_ready, 1);
    check("reset control outputs", {bus.resp_valid, bus.resp_err, bus.mem_en, bus.mem_read,
                                    bus.mem_func}, 0);
    check("reset resp_rdata", bus.resp_rdata, 0);
    check("reset mem_addr|mem_wdata", bus.mem_addr | bus.mem_wdata, 0);

    poke(32'h100, 8'hEF);
    poke(32'h101, 8'hBE);
    poke(32'h102, 8'hAD);
    poke(32'h103, 8'hDE);
    poke(32'hFFFFFFFF, 8'h5A);
    poke(32'h0, 8'h01);
    poke(32'h1, 8'h02);
    poke(32'h2, 8'h03);

    for (int i = 0; i < 24; i++) begin
      do_txn(vt[i].we, vt[i].func, vt[i].addr, vt[i].wdata, vt[i].err, vt[i].rdata, vt[i].bp,
             $sformatf("vec%0d", i));
    end

    // Reset in the middle of a load: mem_en must fall before the next clock edge.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_func  = 3'd2;
    bus.req_addr  = 32'h100;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("midop mem_en before reset", bus.mem_en, 1);
    #2 rst = 1'b1;
    #1;
    check("midop async clear {mem_en,resp_valid}", {bus.mem_en, bus.resp_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midop req_ready after release", bus.req_ready, 1);

    for (int i = 0; i < 200; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_func  = 3'($urandom_range(0, 7));
      r_addr  = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) r_addr = r_addr & ~32'h3;
      r_wdata = $urandom;
      begin
        bit [7:0] snap [1024];
        snap = ref_mem;
        ref_access(r_we, r_func, r_addr, r_wdata, r_err, r_rdata, r_n, r_split);
        ref_mem = snap;
      end
      do_txn(r_we, r_func, r_addr, r_wdata, r_err, r_rdata, $urandom_range(0, 3),
             $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    nmem = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != ref_mem[i]) nmem++;
    check("memory image mismatching bytes", nmem, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
